// File: rtl/id_operand_hazard_unit.sv
// Decode-stage operand unit: register file, EX/MEM/WB forwarding, load-use
// stall detection for a configurable load latency, and the ID/EX register.
module id_operand_hazard_unit #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [NRD*AW-1:0]   id_rs_addr,
  input  logic [NRD-1:0]      id_rs_used,
  input  logic [XLEN-1:0]     id_imm,
  input  logic [AW-1:0]       id_rd,
  input  logic                id_wreg,
  input  logic                id_m2reg,
  input  logic                flush,
  input  logic [XLEN-1:0]     ex_aluR,
  input  logic [XLEN-1:0]     mem_aluR,
  input  logic [XLEN-1:0]     mem_mdata,
  input  logic [AW-1:0]       wb_destR,
  input  logic [XLEN-1:0]     wb_dest,
  input  logic                wb_wreg,
  input  logic [AW-1:0]       which_reg,
  output logic                id_stall,
  output logic                ex_valid,
  output logic [NRD*XLEN-1:0] ex_opnd,
  output logic [XLEN-1:0]     ex_imm,
  output logic [AW-1:0]       ex_rd,
  output logic                ex_wreg,
  output logic                ex_m2reg,
  output logic [XLEN-1:0]     reg_content
);

  localparam int NREG = 1 << AW;

  logic [XLEN-1:0]     rf_q [NREG];
  logic [XLEN-1:0]     rf_d [NREG];

  logic                ex_valid_q, ex_valid_d;
  logic [NRD*XLEN-1:0] ex_opnd_q, ex_opnd_d;
  logic [XLEN-1:0]     ex_imm_q, ex_imm_d;
  logic [AW-1:0]       ex_rd_q, ex_rd_d;
  logic                ex_wreg_q, ex_wreg_d;
  logic                ex_m2reg_q, ex_m2reg_d;

  logic [AW-1:0]       mem_rd_q, mem_rd_d;
  logic                mem_wreg_q, mem_wreg_d;
  logic                mem_m2reg_q, mem_m2reg_d;

  logic [NRD*XLEN-1:0] fwd_opnd;
  logic [NRD-1:0]      port_hazard;
  logic                bubble;

  function automatic logic src_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A load in MEM only has its data available here when LOAD_LAT is 1;
  // with LOAD_LAT 2 the value falls through and the stall covers real reads.
  function automatic logic [XLEN-1:0] fwd_val(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    if (src_zero(a))
      v = '0;
    else if (ex_valid_q && ex_wreg_q && !ex_m2reg_q && (ex_rd_q == a))
      v = ex_aluR;
    else if (mem_wreg_q && (mem_rd_q == a) && !mem_m2reg_q)
      v = mem_aluR;
    else if (mem_wreg_q && (mem_rd_q == a) && (LOAD_LAT == 1))
      v = mem_mdata;
    else if (wb_wreg && (wb_destR == a))
      v = wb_dest;
    else
      v = rf_q[a];
    return v;
  endfunction

  function automatic logic load_hit(input logic [AW-1:0] a);
    logic ex_ld;
    logic mem_ld;
    ex_ld  = ex_valid_q && ex_wreg_q && ex_m2reg_q && (ex_rd_q == a);
    mem_ld = (LOAD_LAT == 2) && mem_wreg_q && mem_m2reg_q && (mem_rd_q == a);
    return !src_zero(a) && (ex_ld || mem_ld);
  endfunction

  always_comb begin
    fwd_opnd    = '0;
    port_hazard = '0;
    for (int p = 0; p < NRD; p++) begin
      fwd_opnd[p*XLEN +: XLEN] = fwd_val(id_rs_addr[p*AW +: AW]);
      port_hazard[p]           = id_rs_used[p] && load_hit(id_rs_addr[p*AW +: AW]);
    end
  end

  assign id_stall = id_valid && !flush && (|port_hazard);
  assign bubble   = flush || !id_valid || id_stall;

  always_comb begin
    ex_valid_d = 1'b0;
    ex_opnd_d  = '0;
    ex_imm_d   = '0;
    ex_rd_d    = '0;
    ex_wreg_d  = 1'b0;
    ex_m2reg_d = 1'b0;
    if (!bubble) begin
      ex_valid_d = 1'b1;
      ex_opnd_d  = fwd_opnd;
      ex_imm_d   = id_imm;
      ex_rd_d    = id_rd;
      ex_wreg_d  = id_wreg;
      ex_m2reg_d = id_m2reg;
    end

    mem_rd_d    = ex_valid_q ? ex_rd_q : '0;
    mem_wreg_d  = ex_valid_q && ex_wreg_q;
    mem_m2reg_d = ex_valid_q && ex_m2reg_q;

    rf_d = rf_q;
    if (wb_wreg && !src_zero(wb_destR))
      rf_d[wb_destR] = wb_dest;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_opnd_q   <= '0;
      ex_imm_q    <= '0;
      ex_rd_q     <= '0;
      ex_wreg_q   <= 1'b0;
      ex_m2reg_q  <= 1'b0;
      mem_rd_q    <= '0;
      mem_wreg_q  <= 1'b0;
      mem_m2reg_q <= 1'b0;
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_opnd_q   <= ex_opnd_d;
      ex_imm_q    <= ex_imm_d;
      ex_rd_q     <= ex_rd_d;
      ex_wreg_q   <= ex_wreg_d;
      ex_m2reg_q  <= ex_m2reg_d;
      mem_rd_q    <= mem_rd_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_m2reg_q <= mem_m2reg_d;
      rf_q        <= rf_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_opnd     = ex_opnd_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rd       = ex_rd_q;
  assign ex_wreg     = ex_wreg_q;
  assign ex_m2reg    = ex_m2reg_q;
  assign reg_content = rf_q[which_reg];

endmodule
